// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel prescaler, h/v counters, registered syncs and strobes.
// Optional frame counter port/logic is built when VGA_TIMING_FRAME_COUNT_EN is defined.
module vga_timing_gen #(
   parameter int CLK_DIV   = 4,
   parameter int CNT_W     = 10,
   parameter int H_DISPLAY = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   output logic             pix_stb,
   output logic [CNT_W-1:0] h_count,
   output logic [CNT_W-1:0] v_count,
   output logic [CNT_W-1:0] x_pos,
   output logic [CNT_W-1:0] y_pos,
   output logic             h_sync,
   output logic             v_sync,
   output logic             video_on,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
   ,
   output logic [7:0]       frame_count
`endif
);

   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

   // Window bounds carry one extra bit so a sync ending exactly at the total cannot overflow
   localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_DISPLAY);
   localparam logic [CNT_W:0] HS_BEG    = (CNT_W+1)'(H_DISPLAY + H_FP);
   localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_DISPLAY + H_FP + H_SYNC);
   localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_DISPLAY);
   localparam logic [CNT_W:0] VS_BEG    = (CNT_W+1)'(V_DISPLAY + V_FP);
   localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_DISPLAY + V_FP + V_SYNC);

   logic [PW-1:0]    presc;
   logic             advance;
   logic             h_wrap;
   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;
   logic             h_act;
   logic             v_act;
   logic             hs_on;
   logic             vs_on;
   logic             origin_next;

   // Everything registered below is decoded from the next counts so it lines up with them
   always_comb begin
      advance     = enable && (presc == PRE_LAST);
      h_wrap      = (h_count == H_LAST);
      h_next      = h_wrap ? '0 : h_count + 1'b1;
      v_next      = v_count;
      if (h_wrap) begin
         v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end
      h_act       = ({1'b0, h_next} < H_ACT_END);
      v_act       = ({1'b0, v_next} < V_ACT_END);
      hs_on       = ({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END);
      vs_on       = ({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END);
      origin_next = (h_next == '0) && (v_next == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc       <= '0;
         h_count     <= H_LAST;
         v_count     <= V_LAST;
         x_pos       <= '0;
         y_pos       <= '0;
         h_sync      <= ~HSYNC_POL;
         v_sync      <= ~VSYNC_POL;
         video_on    <= 1'b0;
         pix_stb     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_stb     <= advance;
         line_start  <= advance && (h_next == '0);
         frame_start <= advance && origin_next;
         if (enable) begin
            presc <= advance ? '0 : presc + 1'b1;
         end
         if (advance) begin
            h_count  <= h_next;
            v_count  <= v_next;
            x_pos    <= (h_act && v_act) ? h_next : '0;
            y_pos    <= (h_act && v_act) ? v_next : '0;
            h_sync   <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            v_sync   <= vs_on ? VSYNC_POL : ~VSYNC_POL;
            video_on <= h_act && v_act;
         end
      end
   end

`ifdef VGA_TIMING_FRAME_COUNT_EN
   // Counts on the same edge that raises frame_start, so the first frame reads 1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_count <= 8'd0;
      end else if (advance && origin_next) begin
         frame_count <= frame_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 640x480 timing, a small frame for vertical
// corners, and a CLK_DIV=1 positive-hsync variant.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic reset_n;
   logic enable;

   always #5 clk = ~clk;

   logic       pix_a, hs_a, vs_a, von_a, ls_a, fs_a;
   logic [9:0] h_a, v_a, x_a, y_a;
   logic       pix_b, hs_b, vs_b, von_b, ls_b, fs_b;
   logic [9:0] h_b, v_b, x_b, y_b;
   logic       pix_c, hs_c, vs_c, von_c, ls_c, fs_c;
   logic [9:0] h_c, v_c, x_c, y_c;
`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [7:0] fc_a, fc_b, fc_c;
`endif

   vga_timing_gen dut_a (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .pix_stb(pix_a), .h_count(h_a), .v_count(v_a), .x_pos(x_a), .y_pos(y_a),
      .h_sync(hs_a), .v_sync(vs_a), .video_on(von_a),
      .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_COUNT_EN
      , .frame_count(fc_a)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV(2), .CNT_W(10),
      .H_DISPLAY(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_DISPLAY(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .pix_stb(pix_b), .h_count(h_b), .v_count(v_b), .x_pos(x_b), .y_pos(y_b),
      .h_sync(hs_b), .v_sync(vs_b), .video_on(von_b),
      .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_COUNT_EN
      , .frame_count(fc_b)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV(1), .CNT_W(10),
      .H_DISPLAY(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1)
   ) dut_c (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .pix_stb(pix_c), .h_count(h_c), .v_count(v_c), .x_pos(x_c), .y_pos(y_c),
      .h_sync(hs_c), .v_sync(vs_c), .video_on(von_c),
      .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_TIMING_FRAME_COUNT_EN
      , .frame_count(fc_c)
`endif
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int h; int hs; int von; int x; int y; int ls;
   } vec_a_t;

   typedef struct {
      int h; int v; int hs; int vs; int von; int ls; int fs;
   } vec_b_t;

   vec_a_t tbl_a[9];
   vec_b_t tbl_b[11];

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic rst_val, input logic en_val);
      reset_n = rst_val;
      enable  = en_val;
   endtask

   task automatic wait_a(input int h, input int v);
      bit found = 1'b0;
      for (int i = 0; i < 20000 && !found; i++) begin
         step();
         if (pix_a && int'(h_a) == h && int'(v_a) == v) found = 1'b1;
      end
      if (!found) check_output("wait_a_timeout", 0, 1);
   endtask

   task automatic wait_b(input int h, input int v);
      bit found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         step();
         if (pix_b && int'(h_b) == h && int'(v_b) == v) found = 1'b1;
      end
      if (!found) check_output("wait_b_timeout", 0, 1);
   endtask

   task automatic wait_c(input int h, input int v);
      bit found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         step();
         if (pix_c && int'(h_c) == h && int'(v_c) == v) found = 1'b1;
      end
      if (!found) check_output("wait_c_timeout", 0, 1);
   endtask

   task automatic check_reset_values();
      check_output("rst_a_h", int'(h_a), 799);
      check_output("rst_a_v", int'(v_a), 524);
      check_output("rst_a_hs", int'(hs_a), 1);
      check_output("rst_a_vs", int'(vs_a), 1);
      check_output("rst_a_von", int'(von_a), 0);
      check_output("rst_a_strobes", int'({pix_a, ls_a, fs_a}), 0);
      check_output("rst_a_pos", int'(x_a) + int'(y_a), 0);
      check_output("rst_b_h", int'(h_b), 23);
      check_output("rst_b_v", int'(v_b), 11);
      check_output("rst_c_hv", int'(h_c) * 100 + int'(v_c), 1106);
      check_output("rst_c_hs", int'(hs_c), 0);
      check_output("rst_c_vs", int'(vs_c), 1);
   endtask

   initial begin
      int hs_low;
      int von_high;
      int bad;

      tbl_a[0] = '{h:1,   hs:1, von:1, x:1,   y:1, ls:0};
      tbl_a[1] = '{h:639, hs:1, von:1, x:639, y:1, ls:0};
      tbl_a[2] = '{h:640, hs:1, von:0, x:0,   y:0, ls:0};
      tbl_a[3] = '{h:655, hs:1, von:0, x:0,   y:0, ls:0};
      tbl_a[4] = '{h:656, hs:0, von:0, x:0,   y:0, ls:0};
      tbl_a[5] = '{h:751, hs:0, von:0, x:0,   y:0, ls:0};
      tbl_a[6] = '{h:752, hs:1, von:0, x:0,   y:0, ls:0};
      tbl_a[7] = '{h:799, hs:1, von:0, x:0,   y:0, ls:0};
      tbl_a[8] = '{h:0,   hs:1, von:1, x:0,   y:2, ls:1};

      tbl_b[0]  = '{h:15, v:5,  hs:1, vs:1, von:1, ls:0, fs:0};
      tbl_b[1]  = '{h:18, v:5,  hs:0, vs:1, von:0, ls:0, fs:0};
      tbl_b[2]  = '{h:21, v:5,  hs:0, vs:1, von:0, ls:0, fs:0};
      tbl_b[3]  = '{h:22, v:5,  hs:1, vs:1, von:0, ls:0, fs:0};
      tbl_b[4]  = '{h:0,  v:6,  hs:1, vs:1, von:0, ls:1, fs:0};
      tbl_b[5]  = '{h:0,  v:8,  hs:1, vs:0, von:0, ls:1, fs:0};
      tbl_b[6]  = '{h:23, v:9,  hs:1, vs:0, von:0, ls:0, fs:0};
      tbl_b[7]  = '{h:0,  v:10, hs:1, vs:1, von:0, ls:1, fs:0};
      tbl_b[8]  = '{h:23, v:11, hs:1, vs:1, von:0, ls:0, fs:0};
      tbl_b[9]  = '{h:0,  v:0,  hs:1, vs:1, von:1, ls:1, fs:1};
      tbl_b[10] = '{h:20, v:0,  hs:0, vs:1, von:0, ls:0, fs:0};

      apply_stimulus(1'b0, 1'b1);
      repeat (3) step();
      apply_stimulus(1'b1, 1'b1);
      check_reset_values();

      for (int i = 0; i < 3; i++) begin
         step();
         check_output("first_pix_early", int'(pix_a), 0);
      end
      step();
      check_output("first_pix", int'(pix_a), 1);
      check_output("first_fs", int'(fs_a), 1);
      check_output("first_hv", int'(h_a) + int'(v_a), 0);
      check_output("first_von", int'(von_a), 1);

      hs_low   = 0;
      von_high = 0;
      for (int i = 0; i < 3200; i++) begin
         step();
         if (!hs_a) hs_low++;
         if (von_a) von_high++;
      end
      check_output("line_hsync_clks", hs_low, 384);
      check_output("line_video_clks", von_high, 2560);
      check_output("line1_h", int'(h_a), 0);
      check_output("line1_v", int'(v_a), 1);
      check_output("line1_ls", int'(ls_a), 1);
      check_output("line1_fs", int'(fs_a), 0);

      for (int i = 0; i < 9; i++) begin
         wait_a(tbl_a[i].h, (i == 8) ? 2 : 1);
         check_output($sformatf("a_hs_%0d", i), int'(hs_a), tbl_a[i].hs);
         check_output($sformatf("a_von_%0d", i), int'(von_a), tbl_a[i].von);
         check_output($sformatf("a_x_%0d", i), int'(x_a), tbl_a[i].x);
         check_output($sformatf("a_y_%0d", i), int'(y_a), tbl_a[i].y);
         check_output($sformatf("a_ls_%0d", i), int'(ls_a), tbl_a[i].ls);
      end

      wait_a(300, 2);
      apply_stimulus(1'b1, 1'b0);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (pix_a || ls_a || fs_a || h_a != 10'd300) bad++;
      end
      check_output("freeze_violations", bad, 0);
      apply_stimulus(1'b1, 1'b1);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (pix_a || h_a != 10'd300) bad++;
      end
      check_output("resume_early", bad, 0);
      step();
      check_output("resume_pix", int'(pix_a), 1);
      check_output("resume_h", int'(h_a), 301);

      wait_a(400, 2);
      check_output("pre_reset_x", int'(x_a), 400);
      apply_stimulus(1'b0, 1'b1);
      #1;
      check_reset_values();
      step();
      step();
      apply_stimulus(1'b1, 1'b1);

      for (int i = 0; i < 11; i++) begin
         wait_b(tbl_b[i].h, tbl_b[i].v);
         check_output($sformatf("b_hs_%0d", i), int'(hs_b), tbl_b[i].hs);
         check_output($sformatf("b_vs_%0d", i), int'(vs_b), tbl_b[i].vs);
         check_output($sformatf("b_von_%0d", i), int'(von_b), tbl_b[i].von);
         check_output($sformatf("b_ls_%0d", i), int'(ls_b), tbl_b[i].ls);
         check_output($sformatf("b_fs_%0d", i), int'(fs_b), tbl_b[i].fs);
      end

      wait_c(0, 1);
      bad = 0;
      for (int i = 1; i <= 12; i++) begin
         int exp_h;
         step();
         exp_h = i % 12;
         if (int'(h_c) != exp_h) bad++;
         if (int'(hs_c) != ((exp_h == 9 || exp_h == 10) ? 1 : 0)) bad++;
         if (!pix_c) bad++;
      end
      check_output("c_line_errors", bad, 0);
      wait_c(0, 5);
      check_output("c_vsync_on", int'(vs_c), 0);
      wait_c(0, 6);
      check_output("c_vsync_off", int'(vs_c), 1);
      wait_c(7, 0);
      check_output("c_von_last", int'(von_c), 1);
      step();
      check_output("c_von_h8", int'(von_c), 0);

`ifdef VGA_TIMING_FRAME_COUNT_EN
      apply_stimulus(1'b0, 1'b1);
      step();
      check_output("fc_reset", int'(fc_c), 0);
      apply_stimulus(1'b1, 1'b1);
      step();
      check_output("fc_first", int'(fc_c), 1);
      bad = 1;
      for (int i = 0; i < 30000 && bad < 257; i++) begin
         step();
         if (fs_c) bad++;
      end
      check_output("fc_frames_seen", bad, 257);
      check_output("fc_wrap", int'(fc_c), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
